// File: rtl/lcd_panel_responder.sv
// Cycle-based responder for an HD44780-style 2x16 character LCD bus.
// Decodes transfers on the falling edge of E; keeps DDRAM, address counter, mode flags and busy timer.
module lcd_panel_responder #(
  parameter int EXEC_CYCLES  = 10,
  parameter int CLEAR_CYCLES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RS,
  input  logic       E,
  input  logic       RW,
  input  logic [7:0] DB,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_id,
  output logic       entry_sh,
  output logic       func_dl,
  output logic       func_n,
  output logic       func_f,
  input  logic [4:0] view_addr,
  output logic [7:0] view_char,
  output logic       xfer_strobe,
  output logic       protocol_err
);

  localparam int MAX_CYCLES = (EXEC_CYCLES > CLEAR_CYCLES) ? EXEC_CYCLES : CLEAR_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic          e_q, rs_q, rw_q;
  logic [7:0]    db_q;
  logic [CW-1:0] busy_cnt;
  logic [7:0]    cells [32];

  logic          fe, accept, is_bf_read, is_long_op;
  logic          ac_visible;
  logic [4:0]    ac_cell;
  logic [7:0]    rd_cell;

  // Line-aware AC stepping: lines occupy 0x00-0x27 and 0x40-0x67; wrap goes to the other line.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    r = a - 7'd1;
    if (inc) begin
      r = (a[5:0] < 6'h27) ? a + 7'd1 : {~a[6], 6'h00};
    end else if (a[5:0] == 6'h00) begin
      r = {~a[6], 6'h27};
    end else if (a[5:0] > 6'h27) begin
      r = {a[6], 6'h27};
    end
    return r;
  endfunction

  assign fe         = e_q & ~E;
  assign busy       = (busy_cnt != '0);
  assign is_bf_read = ~rs_q & rw_q;
  assign accept     = fe & (~busy | is_bf_read);
  assign is_long_op = ~rs_q & ~rw_q & (db_q[7:2] == 6'd0) & (db_q[1:0] != 2'd0);

  assign ac_visible = (ac[5:4] == 2'b00);
  assign ac_cell    = {ac[6], ac[3:0]};
  assign rd_cell    = ac_visible ? cells[ac_cell] : 8'h20;
  assign view_char  = cells[view_addr];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    db_oe  = E & RW;
    db_out = 8'h00;
    if (db_oe) begin
      db_out = RS ? rd_cell : {busy, ac};
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      db_q         <= '0;
      busy_cnt     <= '0;
      ac           <= '0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      entry_id     <= 1'b1;
      entry_sh     <= 1'b0;
      func_dl      <= 1'b0;
      func_n       <= 1'b0;
      func_f       <= 1'b0;
      xfer_strobe  <= 1'b0;
      protocol_err <= 1'b0;
      // NOTE: DDRAM is deliberately reset; the visible panel must read as blanks straight out of reset.
      for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
    end else begin
      e_q  <= E;
      rs_q <= RS;
      rw_q <= RW;
      db_q <= DB;

      xfer_strobe <= accept;
      if (fe && !accept) protocol_err <= 1'b1;

      if (accept && !rw_q) begin
        busy_cnt <= is_long_op ? CW'(CLEAR_CYCLES) : CW'(EXEC_CYCLES);
      end else if (busy) begin
        busy_cnt <= busy_cnt - CW'(1);
      end

      if (accept) begin
        if (rs_q) begin
          // Data writes past column 15 are dropped, but AC still advances.
          if (!rw_q && ac_visible) cells[ac_cell] <= db_q;
          ac <= ac_step(ac, entry_id);
        end else if (!rw_q) begin
          casez (db_q)
            8'b1???????: ac <= db_q[6:0];
            8'b01??????: ;
            8'b001?????: {func_dl, func_n, func_f} <= db_q[4:2];
            8'b0001????: if (!db_q[3]) ac <= ac_step(ac, db_q[2]);
            8'b00001???: {disp_on, cursor_on, blink_on} <= db_q[2:0];
            8'b000001??: {entry_id, entry_sh} <= db_q[1:0];
            8'b0000001?: ac <= '0;
            8'b00000001: begin
              ac       <= '0;
              entry_id <= 1'b1;
              for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Self-checking bench for lcd_panel_responder: vector table, directed corner cases,
// and random bus traffic checked against a line/column reference model of the panel.
module tb_lcd_panel_responder;

  localparam int EXEC = 10;
  localparam int CLR  = 30;

  logic       clk = 1'b0;
  logic       rst, RS, E, RW;
  logic [7:0] DB;
  logic [7:0] db_out;
  logic       db_oe, busy;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, entry_id, entry_sh, func_dl, func_n, func_f;
  logic [4:0] view_addr;
  logic [7:0] view_char;
  logic       xfer_strobe, protocol_err;

  always #5 clk = ~clk;

  lcd_panel_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .RS(RS), .E(E), .RW(RW), .DB(DB),
    .db_out(db_out), .db_oe(db_oe), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_id(entry_id), .entry_sh(entry_sh),
    .func_dl(func_dl), .func_n(func_n), .func_f(func_f),
    .view_addr(view_addr), .view_char(view_char),
    .xfer_strobe(xfer_strobe), .protocol_err(protocol_err)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int busy_end = -1;
  int strobes = 0;

  // Reference model of the panel
  logic [7:0] m_cell [32];
  int         m_ac;
  bit         m_id, m_sh, m_d, m_c, m_b, m_dl, m_n, m_f, m_err;

  typedef struct {
    bit         rs;
    bit         rw;
    logic [7:0] db;
    logic [6:0] exp_ac;
    logic [7:0] exp_flags;
    int         exp_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (xfer_strobe) strobes++;
  endtask

  function automatic int m_idx(input int a);
    int line = a / 64;
    int col  = a % 64;
    return (col < 16) ? line * 16 + col : -1;
  endfunction

  function automatic int m_step(input int a, input bit inc);
    int line = a / 64;
    int col  = a % 64;
    if (inc) return (col < 39) ? a + 1 : (1 - line) * 64;
    if (col == 0) return (1 - line) * 64 + 39;
    if (col > 39) return line * 64 + 39;
    return a - 1;
  endfunction

  function automatic logic [7:0] m_flags();
    return {m_d, m_c, m_b, m_id, m_sh, m_dl, m_n, m_f};
  endfunction

  function automatic logic [7:0] dut_flags();
    return {disp_on, cursor_on, blink_on, entry_id, entry_sh, func_dl, func_n, func_f};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
    m_ac = 0; m_id = 1; m_sh = 0; m_d = 0; m_c = 0; m_b = 0;
    m_dl = 0; m_n = 0; m_f = 0; m_err = 0;
    busy_end = -1;
  endtask

  // Apply one transfer whose falling edge is processed at clock edge t.
  task automatic m_apply(input bit rs, input bit rw, input logic [7:0] db, input int t, output bit acc);
    int idx;
    acc = (t > busy_end) || (!rs && rw);
    if (!acc) begin
      m_err = 1;
      return;
    end
    if (rw) begin
      if (rs) m_ac = m_step(m_ac, m_id);
      return;
    end
    busy_end = t + EXEC;
    if (rs) begin
      idx = m_idx(m_ac);
      if (idx >= 0) m_cell[idx] = db;
      m_ac = m_step(m_ac, m_id);
    end else if (db[7]) m_ac = int'(db[6:0]);
    else if (db[6]) begin end
    else if (db[5]) {m_dl, m_n, m_f} = db[4:2];
    else if (db[4]) begin if (!db[3]) m_ac = m_step(m_ac, db[2]); end
    else if (db[3]) {m_d, m_c, m_b} = db[2:0];
    else if (db[2]) {m_id, m_sh} = db[1:0];
    else if (db[1]) begin m_ac = 0; busy_end = t + CLR; end
    else if (db[0]) begin
      for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
      m_ac = 0; m_id = 1; busy_end = t + CLR;
    end
  endtask

  // Drive one bus transfer with E high for 'hi' cycles, then check against the model.
  task automatic xfer(input bit rs, input bit rw, input logic [7:0] db, input int hi,
                      output logic [7:0] rd, output bit acc);
    logic [7:0] exp_rd;
    int idx;
    RS = rs; RW = rw; DB = db; E = 1'b1;
    repeat (hi) tick();
    if (rw) begin
      idx = m_idx(m_ac);
      exp_rd = rs ? ((idx >= 0) ? m_cell[idx] : 8'h20)
                  : {((cyc < busy_end) ? 1'b1 : 1'b0), 7'(m_ac)};
      check("db_oe_read", int'(db_oe), 1);
      check("db_out_read", int'(db_out), int'(exp_rd));
    end
    rd = db_out;
    E = 1'b0;
    tick();
    RW = 1'b0;
    m_apply(rs, rw, db, cyc, acc);
    check("xfer_strobe", int'(xfer_strobe), int'(acc));
    check("protocol_err", int'(protocol_err), int'(m_err));
    check("ac", int'(ac), m_ac);
    check("busy", int'(busy), (cyc < busy_end) ? 1 : 0);
    check("flags", int'(dut_flags()), int'(m_flags()));
  endtask

  task automatic settle();
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) check("busy_timeout", int'(busy), 0);
  endtask

  task automatic check_screen();
    for (int i = 0; i < 32; i++) begin
      view_addr = 5'(i);
      #1;
      check("cell", int'(view_char), int'(m_cell[i]));
    end
    view_addr = '0;
  endtask

  task automatic check_view(input string name, input int addr, input int exp);
    view_addr = 5'(addr);
    #1;
    check(name, int'(view_char), exp);
    view_addr = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    bit         acc;
    int         n;
    string      clock_str;

    clock_str = "12:34:56";
    rst = 1'b1; E = 1'b0; RS = 1'b0; RW = 1'b0; DB = 8'h00; view_addr = '0;
    m_reset();
    tick(); tick();

    // Reset state
    check("rst_ac", int'(ac), 0);
    check("rst_flags", int'(dut_flags()), 8'h10);
    check("rst_busy", int'(busy), 0);
    check("rst_db_oe", int'(db_oe), 0);
    check("rst_db_out", int'(db_out), 0);
    check("rst_strobe", int'(xfer_strobe), 0);
    check("rst_perr", int'(protocol_err), 0);
    check_screen();
    rst = 1'b0;
    tick();
    strobes = 0;

    // Vector table: init sequence followed by the clock string as data writes
    vecs[0] = '{0, 0, 8'h38, 7'h00, 8'b0001_0110, EXEC};
    vecs[1] = '{0, 0, 8'h0F, 7'h00, 8'b1111_0110, EXEC};
    vecs[2] = '{0, 0, 8'h06, 7'h00, 8'b1111_0110, EXEC};
    vecs[3] = '{0, 0, 8'h01, 7'h00, 8'b1111_0110, CLR};
    for (int i = 0; i < 8; i++)
      vecs[4 + i] = '{1, 0, clock_str[i], 7'(i + 1), 8'b1111_0110, EXEC};

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].rs, vecs[i].rw, vecs[i].db, 3, rd, acc);
      check("vec_ac", int'(ac), int'(vecs[i].exp_ac));
      check("vec_flags", int'(dut_flags()), int'(vecs[i].exp_flags));
      n = 0;
      while (busy && n < 100) begin
        n++;
        tick();
      end
      check("vec_busy_len", n, vecs[i].exp_busy);
      if (i == 3) check("init_strobes", strobes, 4);
      repeat (2) tick();
    end
    check("init_perr", int'(protocol_err), 0);
    for (int i = 0; i < 8; i++) check_view("clock_char", i, int'(clock_str[i]));
    check_screen();

    // Column 39 wrap to line 2 with discarded off-screen write
    xfer(0, 0, 8'hA7, 1, rd, acc); settle();
    check("set_27", int'(ac), 8'h27);
    xfer(1, 0, 8'h41, 2, rd, acc); settle();
    check("wrap_40", int'(ac), 8'h40);
    xfer(1, 0, 8'h42, 2, rd, acc); settle();
    check("step_41", int'(ac), 8'h41);
    check_view("line2_col0", 16, 8'h42);
    check_screen();

    // Decrement mode wrap from 0x00 to 0x67
    xfer(0, 0, 8'h04, 1, rd, acc); settle();
    xfer(0, 0, 8'h80, 1, rd, acc); settle();
    xfer(1, 0, 8'h55, 1, rd, acc);
    check("dec_wrap", int'(ac), 8'h67);
    check_view("cell0_55", 0, 8'h55);
    settle();

    // Transfer while busy is rejected; busy-flag read is always honoured
    xfer(1, 0, 8'h77, 1, rd, acc);
    check("write_acc", int'(xfer_strobe), 1);
    xfer(1, 0, 8'h66, 1, rd, acc);
    check("rej_strobe", int'(xfer_strobe), 0);
    check("rej_perr", int'(protocol_err), 1);
    check("rej_ac", int'(ac), 8'h66);
    xfer(0, 1, 8'h00, 1, rd, acc);
    check("bf_busy_bit", int'(rd[7]), 1);
    check("bf_ac", int'(rd[6:0]), 8'h66);
    check("bf_strobe", int'(xfer_strobe), 1);
    settle();
    repeat (3) tick();
    check("perr_sticky", int'(protocol_err), 1);
    check_screen();

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           $urandom_range(1, 3), rd, acc);
      repeat ($urandom_range(0, 36)) tick();
    end
    check_screen();
    settle();

    // Reset asserted during a clear's busy window
    repeat (2) tick();
    xfer(0, 0, 8'h01, 2, rd, acc);
    repeat (3) tick();
    check("clr_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_flags", int'(dut_flags()), 8'h10);
    check("rst_mid_perr", int'(protocol_err), 0);
    check("rst_mid_strobe", int'(xfer_strobe), 0);
    check("rst_mid_ac", int'(ac), 0);
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    check("post_rst_busy", int'(busy), 0);
    check_screen();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
